// File: rtl/morph_filter_nxn.sv
// KSIZE x KSIZE binary dilate/erode on a 1-bit pixel stream, timed by the VTC H/V counters.
// Optional build macro MORPH_PIX_CNT_EN adds a per-frame count of set output pixels.
module morph_filter_nxn #(
    parameter int   IMG_W      = 640,
    parameter int   IMG_H      = 480,
    parameter int   KSIZE      = 3,
    parameter int   CW         = 12,
    parameter logic BORDER_VAL = 1'b0,
    localparam int  CNTW       = $clog2(IMG_W * IMG_H + 1)
) (
    input  logic          PCLK,
    input  logic          RST_N,
    input  logic [CW-1:0] VtcHCnt,
    input  logic [CW-1:0] VtcVCnt,
    input  logic          de,
    input  logic          pix_i,
    input  logic          mode,
    input  logic          enable,
    output logic          pix_o,
    output logic          vld_o
`ifdef MORPH_PIX_CNT_EN
    ,
    output logic [CNTW-1:0] pix_cnt_o,
    output logic            pix_cnt_stb_o
`endif
);

    localparam int R  = (KSIZE - 1) / 2;
    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    logic             accept;
    logic             frame_start;
    logic             border;
    logic [AW-1:0]    addr;
    logic [KSIZE-2:0] line_mem [IMG_W];
    logic [KSIZE-2:0] ram_word;
    logic [KSIZE-1:0] column;
    logic [KSIZE-1:0] win [KSIZE];
    logic             armed;
    logic             mode_q;
    logic             en_q;
    logic             s1_vld;
    logic             s1_border;
    logic             any_one;
    logic             all_one;
    logic             filt;
    logic             pix_next;

    // Out-of-range counter values behave exactly like de=0.
    assign accept      = de && (VtcHCnt < CW'(IMG_W)) && (VtcVCnt < CW'(IMG_H));
    assign frame_start = accept && (VtcHCnt == '0) && (VtcVCnt == '0);
    assign border      = (VtcHCnt < CW'(2 * R)) || (VtcHCnt > CW'(IMG_W - 1 - R)) ||
                         (VtcVCnt < CW'(2 * R)) || (VtcVCnt > CW'(IMG_H - 1 - R));
    assign addr        = VtcHCnt[AW-1:0];
    assign ram_word    = line_mem[addr];
    assign column      = {ram_word, pix_i};

    // Column bit 0 is the current line; older lines shift toward the MSB.
    always_ff @(posedge PCLK) begin
        if (accept) begin
            line_mem[addr] <= {ram_word[KSIZE-3:0], pix_i};
        end
    end

    always_ff @(posedge PCLK or negedge RST_N) begin
        if (!RST_N) begin
            armed     <= 1'b0;
            mode_q    <= 1'b0;
            en_q      <= 1'b0;
            s1_vld    <= 1'b0;
            s1_border <= 1'b0;
            for (int i = 0; i < KSIZE; i++) begin
                win[i] <= '0;
            end
        end else begin
            s1_vld    <= accept && (armed || frame_start);
            s1_border <= border;
            if (frame_start) begin
                armed  <= 1'b1;
                mode_q <= mode;
                en_q   <= enable;
            end
            if (accept) begin
                win[0] <= column;
                for (int i = 1; i < KSIZE; i++) begin
                    win[i] <= win[i-1];
                end
            end
        end
    end

    // win[R][R] is the centre pixel (h-R, v-R) of the newest accepted input.
    always_comb begin
        any_one = 1'b0;
        all_one = 1'b1;
        for (int i = 0; i < KSIZE; i++) begin
            for (int j = 0; j < KSIZE; j++) begin
                any_one = any_one | win[i][j];
                all_one = all_one & win[i][j];
            end
        end
        if (!en_q) begin
            filt = win[R][R];
        end else if (mode_q) begin
            filt = all_one;
        end else begin
            filt = any_one;
        end
        pix_next = s1_border ? BORDER_VAL : filt;
    end

    always_ff @(posedge PCLK or negedge RST_N) begin
        if (!RST_N) begin
            vld_o <= 1'b0;
            pix_o <= 1'b0;
        end else begin
            vld_o <= s1_vld;
            pix_o <= s1_vld ? pix_next : 1'b0;
        end
    end

`ifdef MORPH_PIX_CNT_EN
    logic            s1_first;
    logic            s1_last;
    logic [CNTW-1:0] cnt;
    logic [CNTW-1:0] cnt_sum;

    always_comb begin
        cnt_sum = (s1_first ? '0 : cnt) + {{(CNTW-1){1'b0}}, pix_next};
    end

    // The first output of a frame restarts the count; the last one publishes it.
    always_ff @(posedge PCLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_first      <= 1'b0;
            s1_last       <= 1'b0;
            cnt           <= '0;
            pix_cnt_o     <= '0;
            pix_cnt_stb_o <= 1'b0;
        end else begin
            s1_first      <= frame_start;
            s1_last       <= accept && (VtcHCnt == CW'(IMG_W - 1)) && (VtcVCnt == CW'(IMG_H - 1));
            pix_cnt_stb_o <= 1'b0;
            if (s1_vld) begin
                cnt <= cnt_sum;
                if (s1_last) begin
                    pix_cnt_o     <= cnt_sum;
                    pix_cnt_stb_o <= 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_morph_filter_nxn.sv
// Scoreboard bench for morph_filter_nxn on a 16x12 frame with a 3x3 window.
// Builds with or without MORPH_PIX_CNT_EN.
module tb_morph_filter_nxn;

    localparam int   W    = 16;
    localparam int   H    = 12;
    localparam int   K    = 3;
    localparam int   R    = (K - 1) / 2;
    localparam int   CW   = 12;
    localparam logic BV   = 1'b0;
    localparam int   CNTW = $clog2(W * H + 1);

    logic          PCLK;
    logic          RST_N;
    logic [CW-1:0] VtcHCnt;
    logic [CW-1:0] VtcVCnt;
    logic          de;
    logic          pix_i;
    logic          mode;
    logic          enable;
    logic          pix_o;
    logic          vld_o;
`ifdef MORPH_PIX_CNT_EN
    logic [CNTW-1:0] pix_cnt_o;
    logic            pix_cnt_stb_o;
`endif

    morph_filter_nxn #(
        .IMG_W(W), .IMG_H(H), .KSIZE(K), .CW(CW), .BORDER_VAL(BV)
    ) dut (
        .PCLK(PCLK), .RST_N(RST_N), .VtcHCnt(VtcHCnt), .VtcVCnt(VtcVCnt),
        .de(de), .pix_i(pix_i), .mode(mode), .enable(enable),
        .pix_o(pix_o), .vld_o(vld_o)
`ifdef MORPH_PIX_CNT_EN
        , .pix_cnt_o(pix_cnt_o), .pix_cnt_stb_o(pix_cnt_stb_o)
`endif
    );

    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;
    int   f_vld  = 0;
    int   f_ones = 0;
    logic exp_q [$];
    int   ts_q  [$];
    logic img [H][W];
    logic armed_m = 1'b0;
    logic mode_m  = 1'b0;
    logic en_m    = 1'b0;

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc++;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic logic pattern_bit(input int pat, input int h, input int v);
        case (pat)
            1:       return (h == 8) && (v == 5);
            2:       return (h >= 4) && (h <= 8) && (v >= 3) && (v <= 7);
            3:       return 1'b1;
            4:       return ((h * 7 + v * 3) % 5) == 0;
            default: return 1'b0;
        endcase
    endfunction

    // Reference: output for input (h,v) covers centre (h-R, v-R) of the current frame.
    function automatic logic expected_pix(input int h, input int v);
        logic acc;
        if (h < 2 * R || h > W - 1 - R || v < 2 * R || v > H - 1 - R) return BV;
        if (!en_m) return img[v-R][h-R];
        acc = mode_m;
        for (int dy = 0; dy < K; dy++) begin
            for (int dx = 0; dx < K; dx++) begin
                acc = mode_m ? (acc & img[v-dy][h-dx]) : (acc | img[v-dy][h-dx]);
            end
        end
        return acc;
    endfunction

    task automatic applyStimulus(input int h, input int v, input logic d, input logic p);
        @(negedge PCLK);
        VtcHCnt = h[CW-1:0];
        VtcVCnt = v[CW-1:0];
        de      = d;
        pix_i   = p;
        if (d && h < W && v < H) begin
            img[v][h] = p;
            if (h == 0 && v == 0) begin
                armed_m = 1'b1;
                mode_m  = mode;
                en_m    = enable;
            end
            if (armed_m) begin
                exp_q.push_back(expected_pix(h, v));
                ts_q.push_back(cyc);
            end
        end
    endtask

    task automatic doReset();
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1'b0, 1'b0);
        RST_N = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK);
        checkOutput("reset_vld", int'(vld_o), 0);
        checkOutput("reset_pix", int'(pix_o), 0);
        exp_q.delete();
        ts_q.delete();
        armed_m = 1'b0;
        RST_N = 1'b1;
    endtask

    task automatic runFrame(input int pat, input int first_line, input logic m, input logic en,
                            input int mode_line, input int en_line, input int reset_line,
                            input int exp_vld, input int exp_ones);
        mode   = m;
        enable = en;
        f_vld  = 0;
        f_ones = 0;
        for (int v = first_line; v < H + 2; v++) begin
            if (v == mode_line) mode = ~mode;
            if (v == en_line) enable = 1'b0;
            if (v == reset_line) doReset();
            for (int h = 0; h < W + 4; h++) begin
                if (h == 6) applyStimulus(h, v, 1'b0, 1'b1);
                applyStimulus(h, v, (h < W) || (v == 3) || (v == H),
                              pattern_bit(pat, h, v) || (h >= W) || (v >= H));
            end
        end
        for (int i = 0; i < 3; i++) applyStimulus(0, H + 2, 1'b0, 1'b0);
        checkOutput("frame_vld_count", f_vld, exp_vld);
        if (exp_ones >= 0) checkOutput("frame_ones_count", f_ones, exp_ones);
        checkOutput("scoreboard_drained", exp_q.size(), 0);
    endtask

    // Monitor: every vld_o pops the scoreboard and checks value and 2-cycle latency.
    always @(negedge PCLK) begin
        logic e;
        int   t;
        if (RST_N && vld_o) begin
            f_vld++;
            if (pix_o) f_ones++;
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("[TB] FAIL unexpected_vld: vld_o=1 pix_o=%0b with no pending expectation", pix_o);
            end else begin
                e = exp_q.pop_front();
                t = ts_q.pop_front();
                if (pix_o !== e || (cyc - t) != 2) begin
                    fails++;
                    $display("[TB] FAIL pix_out: got pix=%0b latency=%0d, expected pix=%0b latency=2",
                             pix_o, cyc - t, e);
                end
            end
        end
`ifdef MORPH_PIX_CNT_EN
        if (RST_N && pix_cnt_stb_o) checkOutput("pix_cnt", int'(pix_cnt_o), f_ones);
`endif
    end

    initial begin
        RST_N   = 1'b0;
        VtcHCnt = '0;
        VtcVCnt = '0;
        de      = 1'b0;
        pix_i   = 1'b0;
        mode    = 1'b0;
        enable  = 1'b1;
        repeat (3) @(negedge PCLK);
        checkOutput("reset_vld", int'(vld_o), 0);
        checkOutput("reset_pix", int'(pix_o), 0);
        RST_N = 1'b1;

        // Partial frame after reset: never armed, no outputs.
        runFrame(4, 4, 1'b0, 1'b1, -1, -1, -1, 0, 0);
        // Dilate single pixel -> 3x3.
        runFrame(1, 0, 1'b0, 1'b1, -1, -1, -1, W * H, 9);
        // Erode 5x5 block -> 3x3.
        runFrame(2, 0, 1'b1, 1'b1, -1, -1, -1, W * H, 9);
        // All-ones erode: only the unmasked interior stays set.
        runFrame(3, 0, 1'b1, 1'b1, -1, -1, -1, W * H, 117);
        // Mid-frame mode toggle and bypass request must not affect this frame.
        runFrame(2, 0, 1'b1, 1'b1, 6, 8, -1, W * H, 9);
        // Next frame picks up dilate + bypass: block delayed by (R,R).
        runFrame(2, 0, 1'b0, 1'b0, -1, -1, -1, W * H, 25);
        // Dilate 5x5 block -> 7x7.
        runFrame(2, 0, 1'b0, 1'b1, -1, -1, -1, W * H, 49);
        // Reset at line 5 drops the rest of the frame.
        runFrame(4, 0, 1'b0, 1'b1, -1, -1, 5, 5 * W, -1);
        // Re-armed frames.
        runFrame(4, 0, 1'b1, 1'b1, -1, -1, -1, W * H, -1);
        runFrame(3, 0, 1'b0, 1'b1, -1, -1, -1, W * H, 117);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
